// File: rtl/mem_access_stage.sv
// Memory stage of the Small MIPS pipeline: performs LW/SW over a req/ack
// data-memory port, passes other ALU results through, and emits a one-cycle
// write-back record. Upstream is stalled while a memory access is outstanding.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_store,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_err
);

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam int         CW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          wb_valid_q, wb_valid_d;
  logic          wb_we_q, wb_we_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          wb_err_q, wb_err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Destination and write-enable of the outstanding load/store
  logic [4:0]    rd_lat_q, rd_lat_d;
  logic          we_lat_q, we_lat_d;

  logic is_mem_op;

  assign is_mem_op = (in_opcode == OP_LW) || (in_opcode == OP_SW);
  assign in_ready  = (state_q == IDLE);

  // Next-state and next-output logic for the IDLE/REQ controller
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = wb_we_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    wb_err_d    = wb_err_q;
    cnt_d       = cnt_q;
    rd_lat_d    = rd_lat_q;
    we_lat_d    = we_lat_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem_op) begin
            wb_valid_d = 1'b1;
            wb_data_d  = in_alu;
            wb_rd_d    = in_rd;
            wb_we_d    = in_reg_we;
            wb_err_d   = 1'b0;
          end else if (in_alu[1:0] != 2'b00) begin
            // Misaligned access: fault record, memory is never touched
            wb_valid_d = 1'b1;
            wb_data_d  = in_alu;
            wb_rd_d    = in_rd;
            wb_we_d    = 1'b0;
            wb_err_d   = 1'b1;
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = (in_opcode == OP_SW);
            mem_addr_d  = in_alu;
            mem_wdata_d = in_store;
            rd_lat_d    = in_rd;
            we_lat_d    = in_reg_we;
            cnt_d       = '0;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          // Ack takes priority over a timeout in the same cycle
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_lat_q;
          wb_err_d   = 1'b0;
          wb_data_d  = mem_we_q ? mem_addr_q : mem_rdata;
          wb_we_d    = mem_we_q ? 1'b0 : we_lat_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_lat_q;
          wb_err_d   = 1'b1;
          wb_data_d  = mem_addr_q;
          wb_we_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, cleared by synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      wb_err_q    <= 1'b0;
      cnt_q       <= '0;
      rd_lat_q    <= '0;
      we_lat_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      wb_err_q    <= wb_err_d;
      cnt_q       <= cnt_d;
      rd_lat_q    <= rd_lat_d;
      we_lat_q    <= we_lat_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_we     = wb_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign wb_err    = wb_err_q;

endmodule
